traffic_light_module: RTL and testbench

- Three-phase traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, repeating.
- Each phase lasts a programmable number of *enabled* clock cycles.
- When enable is low, the controller freezes in its current phase and count.
- Standalone leaf block. It drives one-hot lamp outputs for a single signal head from a single clock domain.

---
 rtl/traffic_light_pkg.sv | 32 +++
 rtl/tl_phase_timer.sv | 32 +++
 rtl/traffic_light_module.sv | 109 ++++++++++
 tb/tb_traffic_light_module.sv | 126 ++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the three-phase traffic-light sequencer.
package traffic_light_pkg;

    // Phase encoding; 2'b11 is unused and treated as a recoverable fault.
    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } light_state_e;

    // Default number of enabled cycles spent in each phase.
    localparam int unsigned DEF_RED_CYCLES    = 5;
    localparam int unsigned DEF_GREEN_CYCLES  = 4;
    localparam int unsigned DEF_YELLOW_CYCLES = 2;
    localparam int unsigned DEF_CNT_W         = 8;

    // Timer reload value for a phase: its duration minus one, so the phase
    // is visible for exactly its duration in enabled edges.
    function automatic int unsigned phase_len_m1(
        input light_state_e s,
        input int unsigned  red_c,
        input int unsigned  green_c,
        input int unsigned  yellow_c
    );
        case (s)
            GREEN:   return green_c - 1;
            YELLOW:  return yellow_c - 1;
            default: return red_c - 1;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter with count enable and a zero flag. Load wins over
// counting; the counter parks at zero rather than wrapping.
module tl_phase_timer #(
    parameter int unsigned     CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: reset value, reload on phase entry, else count down.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            cnt_q <= RESET_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_module.sv
// Three-phase traffic-light sequencer RED -> GREEN -> YELLOW -> RED with
// programmable per-phase durations counted in enabled clock cycles and
// registered one-hot lamp outputs.
module traffic_light_module
    import traffic_light_pkg::*;
#(
    parameter int unsigned RED_CYCLES    = DEF_RED_CYCLES,
    parameter int unsigned GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam logic [CNT_W-1:0] RED_M1 = CNT_W'(RED_CYCLES - 1);

    light_state_e     state_q, state_d;
    logic             timer_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             red_q, yellow_q, green_q;
    logic             red_d, yellow_d, green_d;

    // Phase timer: reset loads the full RED count, phase entry reloads it.
    tl_phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (RED_M1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (enable),
        .zero     (timer_zero)
    );

    // State and lamp registers; reset forces RED regardless of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RED;
            red_q    <= 1'b1;
            yellow_q <= 1'b0;
            green_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    // Next phase: advance only on an enabled edge with the timer expired;
    // an illegal encoding falls back to RED unconditionally.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            RED: begin
                if (enable && timer_zero) begin
                    state_d    = GREEN;
                    timer_load = 1'b1;
                end
            end
            GREEN: begin
                if (enable && timer_zero) begin
                    state_d    = YELLOW;
                    timer_load = 1'b1;
                end
            end
            YELLOW: begin
                if (enable && timer_zero) begin
                    state_d    = RED;
                    timer_load = 1'b1;
                end
            end
            default: begin
                state_d    = RED;
                timer_load = 1'b1;
            end
        endcase
        timer_load_val = CNT_W'(phase_len_m1(state_d, RED_CYCLES,
                                             GREEN_CYCLES, YELLOW_CYCLES));
    end

    // Lamp decode from the next phase so the lamps change on the same edge
    // as the state; anything not GREEN or YELLOW shows RED only.
    always_comb begin
        red_d    = 1'b0;
        yellow_d = 1'b0;
        green_d  = 1'b0;
        case (state_d)
            GREEN:   green_d  = 1'b1;
            YELLOW:  yellow_d = 1'b1;
            default: red_d    = 1'b1;
        endcase
    end

    assign red    = red_q;
    assign yellow = yellow_q;
    assign green  = green_q;

endmodule

// File: tb/tb_traffic_light_module.sv
// Self-checking bench: one instance with default durations and one with all
// durations set to 1, both driven by the same reset/enable stream and
// compared every cycle against a phase/elapsed-count reference model.
module tb_traffic_light_module;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic red_a, yellow_a, green_a;
    logic red_b, yellow_b, green_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase index 0=red 1=green 2=yellow, enabled edges seen.
    int dur_a[3] = '{5, 4, 2};
    int dur_b[3] = '{1, 1, 1};
    int phase_a = 0, elapsed_a = 0;
    int phase_b = 0, elapsed_b = 0;

    always #5 clk = ~clk;

    traffic_light_module dut_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .red    (red_a),
        .yellow (yellow_a),
        .green  (green_a)
    );

    traffic_light_module #(
        .RED_CYCLES    (1),
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1),
        .CNT_W         (8)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .red    (red_b),
        .yellow (yellow_b),
        .green  (green_b)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Lamp vector {red, yellow, green} for a model phase.
    function automatic logic [2:0] lamps(input int phase);
        case (phase)
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic e, input int dur[3],
                              inout int phase, inout int elapsed);
        if (r) begin
            phase   = 0;
            elapsed = 0;
        end else if (e) begin
            elapsed++;
            if (elapsed == dur[phase]) begin
                phase   = (phase + 1) % 3;
                elapsed = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check after it.
    task automatic step(input logic r, input logic e);
        logic [2:0] obs_a, obs_b;
        reset  = r;
        enable = e;
        @(posedge clk);
        model_edge(r, e, dur_a, phase_a, elapsed_a);
        model_edge(r, e, dur_b, phase_b, elapsed_b);
        #1;
        obs_a = {red_a, yellow_a, green_a};
        obs_b = {red_b, yellow_b, green_b};
        check("lamps_default", obs_a, lamps(phase_a));
        check("lamps_dur1", obs_b, lamps(phase_b));
        check("onehot_default", {2'b00, $countones(obs_a) == 1}, 3'b001);
        check("onehot_dur1", {2'b00, $countones(obs_b) == 1}, 3'b001);
    endtask

    initial begin
        // Reset with enable low, then hold RED for 20 cycles.
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

        // Continuous enable: three full 11-edge cycles.
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1);

        // Enable gap in GREEN after 2 enabled edges.
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Intermittent enable toggling every 3 cycles.
        step(1'b1, 1'b0);
        for (int i = 0; i < 66; i++) step(1'b0, ((i / 3) % 2) == 0);

        // Mid-phase reset while YELLOW is lit, with enable high.
        for (int i = 0; i < 20 && phase_a != 2; i++) step(1'b0, 1'b1);
        check("reach_yellow", {red_a, yellow_a, green_a}, 3'b010);
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);

        // Randomized enable with occasional resets.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
